// File: rtl/rle_pkg.sv
// Shared RLE word format and decoder state encoding.
// Imported by both the capture-side encoder and the readback decoder.
package rle_pkg;

    localparam int RLE_SW       = 15;
    localparam int RLE_CW       = 15;
    localparam int RLE_FLAG_BIT = RLE_SW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_RUN  = 2'd2
    } rle_state_e;

endpackage

// File: rtl/rle_decoder.sv
// Expands the RLE word stream back into raw samples.
// A registered output stage sits behind a valid/ready handshake on both sides.
module rle_decoder
    import rle_pkg::*;
#(
    parameter int SW     = RLE_SW,
    parameter int CW     = RLE_CW,
    parameter int SCNT_W = 32
) (
    input  logic              core_clk,
    input  logic              core_rst,
    input  logic              clr,
    input  logic [SW:0]       in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [SW-1:0]     out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              err_orphan,
    output logic [SCNT_W-1:0] sample_cnt
);

    rle_state_e        state_q, state_d;
    logic [SW-1:0]     last_q, last_d;
    logic [CW-1:0]     remain_q, remain_d;
    logic [SW-1:0]     out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              err_q, err_d;
    logic [SCNT_W-1:0] cnt_q;

    logic              slot_free;
    logic              accept;
    logic              is_count;
    logic [CW-1:0]     run_len;

    assign slot_free = !out_valid_q || out_ready;
    // Held low while reset or clear is active so no word is swallowed by the clear.
    assign in_ready  = slot_free && (state_q != S_RUN) && !core_rst && !clr;
    assign accept    = in_valid && in_ready;
    assign is_count  = in_data[SW];
    assign run_len   = in_data[CW-1:0];

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            state_q     <= S_IDLE;
            last_q      <= '0;
            remain_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else if (clr) begin
            state_q     <= S_IDLE;
            last_q      <= '0;
            remain_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            remain_q    <= remain_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        remain_d    = remain_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        err_d       = err_q;

        // A consumed output slot empties unless something below refills it.
        if (slot_free) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!is_count) begin
                        out_data_d  = in_data[SW-1:0];
                        out_valid_d = 1'b1;
                        last_d      = in_data[SW-1:0];
                        state_d     = S_HOLD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (accept) begin
                    if (!is_count) begin
                        out_data_d  = in_data[SW-1:0];
                        out_valid_d = 1'b1;
                        last_d      = in_data[SW-1:0];
                    end else if (run_len != '0) begin
                        remain_d = run_len;
                        state_d  = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (slot_free) begin
                    out_data_d  = last_q;
                    out_valid_d = 1'b1;
                    remain_d    = remain_q - 1'b1;
                    if (remain_q == CW'(1)) begin
                        state_d = S_HOLD;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (out_valid_q && out_ready) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign err_orphan = err_q;
    assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_rle_decoder.sv
// Self-checking bench for rle_decoder: table vectors, hand-timed corner sequences and
// random streams compared against a queue-based expansion model.
module tb_rle_decoder;

    logic        core_clk = 1'b0;
    logic        core_rst;
    logic        clr;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        err_orphan;
    logic [31:0] sample_cnt;

    int total = 0;
    int bad   = 0;

    always #5 core_clk = ~core_clk;

    rle_decoder dut (
        .core_clk   (core_clk),
        .core_rst   (core_rst),
        .clr        (clr),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .err_orphan (err_orphan),
        .sample_cnt (sample_cnt)
    );

    logic [15:0] stim[$];
    logic [14:0] got[$];
    logic [14:0] exp_q[$];
    bit          exp_err;
    int          nready;
    int          stall_bad;
    bit          timed_out;

    typedef struct {
        logic [15:0] w0, w1, w2, w3;
        int          n;
        int          rmode;
        int          exp_n;
        logic [14:0] first;
        logic [14:0] last;
        bit          err;
        int          exp_nready;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic add(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                       input logic [15:0] w3, input int n, input int rmode, input int exp_n,
                       input logic [14:0] first, input logic [14:0] last, input bit err,
                       input int exp_nready);
        vec_t v;
        v.w0 = w0; v.w1 = w1; v.w2 = w2; v.w3 = w3;
        v.n = n; v.rmode = rmode; v.exp_n = exp_n;
        v.first = first; v.last = last; v.err = err; v.exp_nready = exp_nready;
        tbl.push_back(v);
    endtask

    // Reference: a sample emits itself once, a count word N appends N copies of the
    // most recent sample, a count before any sample flags an orphan.
    function automatic void model();
        logic [14:0] last = '0;
        bit          seen = 1'b0;
        exp_q.delete();
        exp_err = 1'b0;
        foreach (stim[i]) begin
            if (!stim[i][15]) begin
                exp_q.push_back(stim[i][14:0]);
                last = stim[i][14:0];
                seen = 1'b1;
            end else if (!seen) begin
                exp_err = 1'b1;
            end else begin
                for (int k = 0; k < int'(stim[i][14:0]); k++) exp_q.push_back(last);
            end
        end
    endfunction

    task automatic apply_clr();
        @(posedge core_clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        clr       = 1'b1;
        @(posedge core_clk); #1;
        clr = 1'b0;
    endtask

    // rmode: 0 = always ready, 1 = ready every third cycle, 2 = random ready.
    task automatic run_stream(input int rmode, input int budget);
        int          idx = 0;
        int          cyc = 0;
        bit          prev_stall = 1'b0;
        logic [14:0] prev_data = '0;
        got.delete();
        nready    = 0;
        stall_bad = 0;
        timed_out = 1'b0;
        forever begin
            if (cyc >= budget) begin
                timed_out = 1'b1;
                break;
            end
            @(posedge core_clk); #1;
            in_valid = (idx < stim.size());
            in_data  = in_valid ? stim[idx] : 16'h0000;
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge core_clk);
            if (prev_stall && (!out_valid || out_data !== prev_data)) stall_bad++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (idx == stim.size() && !out_valid && in_ready) break;
            if (out_valid && out_ready) got.push_back(out_data);
            if (in_valid && in_ready) idx++;
            else if (in_valid) nready++;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic do_stream(input string tag, input int rmode, input int budget);
        int mism = 0;
        run_stream(rmode, budget);
        model();
        check({tag, " timeout"}, timed_out, 0);
        check({tag, " out_count"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            if (got[i] !== exp_q[i]) mism++;
        check({tag, " data_mismatches"}, mism, 0);
        check({tag, " err_orphan"}, err_orphan, exp_err);
        check({tag, " sample_cnt"}, sample_cnt, exp_q.size());
        if (rmode != 0) check({tag, " stall_hold"}, stall_bad, 0);
    endtask

    task automatic start_run_0044();
        @(posedge core_clk); #1;
        in_valid = 1'b1; in_data = 16'h0044; out_ready = 1'b1;
        @(posedge core_clk); #1;
        in_data = 16'h8010;
        @(posedge core_clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge core_clk);
        #1;
    endtask

    initial begin
        core_rst  = 1'b1;
        clr       = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h0005;
        out_ready = 1'b1;

        repeat (2) @(negedge core_clk);
        check("rst in_ready", in_ready, 0);
        check("rst out_valid", out_valid, 0);
        check("rst out_data", out_data, 0);
        check("rst err_orphan", err_orphan, 0);
        check("rst sample_cnt", sample_cnt, 0);
        in_valid = 1'b0;
        #2 core_rst = 1'b0;
        #1 check("post-rst in_ready", in_ready, 1);

        // Consecutive samples: one-cycle latency, back-to-back outputs.
        apply_clr();
        for (int c = 0; c < 5; c++) begin
            @(posedge core_clk); #1;
            in_valid  = (c < 3);
            in_data   = 16'(5 + c);
            out_ready = 1'b1;
            @(negedge core_clk);
            if (c < 3) check("lat in_ready", in_ready, 1);
            if (c >= 1 && c <= 3) begin
                check("lat out_valid", out_valid, 1);
                check("lat out_data", out_data, 15'(4 + c));
            end
            if (c == 4) begin
                check("lat drained", out_valid, 0);
                check("lat sample_cnt", sample_cnt, 3);
            end
        end

        add(16'h0005, 16'h0006, 16'h0007, 16'h0000, 3, 0, 3, 15'h0005, 15'h0007, 0, 0);
        add(16'h0A5A, 16'h8003, 16'h0001, 16'h0000, 3, 0, 5, 15'h0A5A, 15'h0001, 0, 3);
        add(16'h8002, 16'h0001, 16'h0000, 16'h0000, 2, 0, 1, 15'h0001, 15'h0001, 1, 0);
        add(16'h0011, 16'h8000, 16'h0022, 16'h0000, 3, 0, 2, 15'h0011, 15'h0022, 0, 0);
        add(16'h0033, 16'h8005, 16'h0000, 16'h0000, 2, 1, 6, 15'h0033, 15'h0033, 0, -1);
        add(16'h0007, 16'h8001, 16'h8002, 16'h0009, 4, 0, 5, 15'h0007, 15'h0009, 0, 3);
        add(16'h8000, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 15'h0000, 15'h0000, 1, 0);
        add(16'h0012, 16'h0013, 16'h8004, 16'h0000, 3, 2, 6, 15'h0012, 15'h0013, 0, -1);

        foreach (tbl[t]) begin
            string tag;
            tag = $sformatf("vec%0d", t);
            apply_clr();
            stim.delete();
            stim.push_back(tbl[t].w0);
            if (tbl[t].n > 1) stim.push_back(tbl[t].w1);
            if (tbl[t].n > 2) stim.push_back(tbl[t].w2);
            if (tbl[t].n > 3) stim.push_back(tbl[t].w3);
            do_stream(tag, tbl[t].rmode, 500);
            check({tag, " exp_n"}, got.size(), tbl[t].exp_n);
            check({tag, " exp_err"}, err_orphan, tbl[t].err);
            if (tbl[t].exp_n > 0 && got.size() > 0) begin
                check({tag, " first"}, got[0], tbl[t].first);
                check({tag, " last"}, got[got.size() - 1], tbl[t].last);
            end
            if (tbl[t].exp_nready >= 0) check({tag, " in_ready_low"}, nready, tbl[t].exp_nready);
        end

        // Synchronous clear in the middle of a long run.
        apply_clr();
        start_run_0044();
        check("clr pre out_valid", out_valid, 1);
        clr = 1'b1;
        @(posedge core_clk); #1;
        clr = 1'b0;
        check("clr out_valid", out_valid, 0);
        check("clr sample_cnt", sample_cnt, 0);
        check("clr out_data", out_data, 0);
        stim.delete();
        stim.push_back(16'h8001);
        do_stream("clr idle-orphan", 0, 200);
        apply_clr();
        stim.delete();
        stim.push_back(16'h0001);
        do_stream("clr resume", 0, 200);

        // Asynchronous reset in the middle of a long run.
        apply_clr();
        start_run_0044();
        @(negedge core_clk);
        check("arst pre out_valid", out_valid, 1);
        #2 core_rst = 1'b1;
        #1;
        check("arst out_valid", out_valid, 0);
        check("arst sample_cnt", sample_cnt, 0);
        check("arst in_ready", in_ready, 0);
        #1 core_rst = 1'b0;
        stim.delete();
        stim.push_back(16'h0005);
        stim.push_back(16'h8001);
        do_stream("arst resume", 0, 200);

        // Overflow chain of two maximal count words.
        apply_clr();
        stim.delete();
        stim.push_back(16'h0001);
        stim.push_back(16'hFFFF);
        stim.push_back(16'hFFFF);
        do_stream("long", 0, 70000);
        check("long total", got.size(), 65535);

        for (int r = 0; r < 6; r++) begin
            apply_clr();
            stim.delete();
            for (int k = 0; k < 24; k++) begin
                if ($urandom_range(0, 9) < 6) stim.push_back({1'b0, 15'($urandom)});
                else stim.push_back({1'b1, 15'($urandom_range(0, 6))});
            end
            do_stream($sformatf("rand%0d", r), 2, 3000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
